// File: rtl/pc_pkg.sv
// Shared constants for the program counter: default widths, reset address and jump modes.
package pc_pkg;

    localparam int unsigned  PC_ADDR_W     = 8;
    localparam logic [7:0]   PC_RESET_ADDR = 8'h00;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'b00,
        PC_ABS      = 2'b01,
        PC_REL      = 2'b10,
        PC_HOLD_RET = 2'b11
    } pc_mode_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the program counter; a push when full overwrites the oldest entry.
module pc_ret_stack #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [PTR_W-1:0]  w_wr_ptr_inc;

    assign w_rd_ptr     = (r_wr_ptr == '0) ? PTR_W'(DEPTH - 1) : r_wr_ptr - PTR_W'(1);
    assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign o_full       = (r_count == CNT_W'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_top        = r_mem[w_rd_ptr];
    assign o_err        = r_err;

    // NOTE: storage is deliberately not reset; r_count alone defines which entries are valid.
    always_ff @(posedge i_Clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (i_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
                if (o_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (i_pop) begin
                if (o_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_wr_ptr <= w_rd_ptr;
                    r_count  <= r_count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter with sequential, absolute and relative updates plus a one-cycle-delayed copy.
// Optional return stack (call on mode 01, return on mode 11) enabled by `define PC_RET_STACK_EN.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR),
    parameter int unsigned       STACK_DEPTH = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Control_PC,
    input  logic [1:0]        i_Control_Saltos,
    input  logic [ADDR_W-1:0] i_Direccion_Salto,
    output logic [ADDR_W-1:0] o_Direccion_Instrucciones,
    output logic [ADDR_W-1:0] o_Direccion_PC
`ifdef PC_RET_STACK_EN
    ,
    output logic              o_Stack_Err
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_prev;
    logic [ADDR_W-1:0] w_pc_next;

`ifdef PC_RET_STACK_EN
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_stack_top;
    logic              w_stack_empty;
    logic              w_stack_full;

    pc_ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ret_stack (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc + ADDR_W'(1)),
        .o_top   (w_stack_top),
        .o_full  (w_stack_full),
        .o_empty (w_stack_empty),
        .o_err   (o_Stack_Err)
    );
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_pc_next = r_pc;
`ifdef PC_RET_STACK_EN
        w_push = 1'b0;
        w_pop  = 1'b0;
`endif
        if (i_Control_PC) begin
            case (pc_mode_e'(i_Control_Saltos))
                PC_SEQ: w_pc_next = r_pc + ADDR_W'(1);
                PC_ABS: begin
                    w_pc_next = i_Direccion_Salto;
`ifdef PC_RET_STACK_EN
                    w_push = 1'b1;
`endif
                end
                // Same-width two's-complement add equals adding the sign-extended offset mod 2^ADDR_W.
                PC_REL: w_pc_next = r_pc + i_Direccion_Salto;
                PC_HOLD_RET: begin
`ifdef PC_RET_STACK_EN
                    w_pop     = 1'b1;
                    w_pc_next = w_stack_empty ? RESET_ADDR : w_stack_top;
`else
                    w_pc_next = r_pc;
`endif
                end
                default: w_pc_next = r_pc;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_pc      <= RESET_ADDR;
            r_pc_prev <= RESET_ADDR;
        end else begin
            r_pc      <= w_pc_next;
            r_pc_prev <= r_pc;
        end
    end

    assign o_Direccion_Instrucciones = r_pc;
    assign o_Direccion_PC            = r_pc_prev;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan followed by randomized cycles against a reference model.
module tb_program_counter;

    logic       clk;
    logic       rst_n;
    logic       ctl_pc;
    logic [1:0] ctl_mode;
    logic [7:0] jump;
    logic [7:0] o_instr;
    logic [7:0] o_prev;
`ifdef PC_RET_STACK_EN
    logic       o_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_pc   = 0;
    int m_prev = 0;
    bit m_err  = 0;
    int m_stack[$];

    program_counter dut (
        .i_Clk                     (clk),
        .i_Rst                     (rst_n),
        .i_Control_PC              (ctl_pc),
        .i_Control_Saltos          (ctl_mode),
        .i_Direccion_Salto         (jump),
        .o_Direccion_Instrucciones (o_instr),
        .o_Direccion_PC            (o_prev)
`ifdef PC_RET_STACK_EN
        ,
        .o_Stack_Err               (o_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc"}, int'(o_instr), m_pc);
        check({tag, ".prev"}, int'(o_prev), m_prev);
`ifdef PC_RET_STACK_EN
        check({tag, ".err"}, int'(o_err), int'(m_err));
`endif
    endtask

    // Reference model: what the PC should become after one edge with the given inputs.
    task automatic model_edge(input bit en, input int mode, input int tgt);
        int nxt;
        int off;
        nxt    = m_pc;
        m_err  = 0;
        if (en) begin
            case (mode)
                0: nxt = (m_pc + 1) % 256;
                1: begin
                    nxt = tgt;
`ifdef PC_RET_STACK_EN
                    if (m_stack.size() == 4) begin
                        void'(m_stack.pop_front());
                        m_err = 1;
                    end
                    m_stack.push_back((m_pc + 1) % 256);
`endif
                end
                2: begin
                    off = (tgt >= 128) ? tgt - 256 : tgt;
                    nxt = ((m_pc + off) % 256 + 256) % 256;
                end
                default: begin
`ifdef PC_RET_STACK_EN
                    if (m_stack.size() == 0) begin
                        nxt   = 0;
                        m_err = 1;
                    end else begin
                        nxt = m_stack.pop_back();
                    end
`endif
                end
            endcase
        end
        m_prev = m_pc;
        m_pc   = nxt;
    endtask

    // Called 1 time unit after a rising edge; drives inputs, waits one edge, checks.
    task automatic step(input string tag, input bit en, input logic [1:0] mode, input logic [7:0] tgt);
        ctl_pc   = en;
        ctl_mode = mode;
        jump     = tgt;
        @(posedge clk);
        model_edge(en, int'(mode), int'(tgt));
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset between edges and checks the outputs respond without a clock.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_pc   = 0;
        m_prev = 0;
        m_err  = 0;
        m_stack.delete();
        check_outputs(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ctl_pc   = 1'b0;
        ctl_mode = 2'b00;
        jump     = 8'h00;
        #1;
        check_outputs("reset");
        #6 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) step("seq_to5", 1'b1, 2'b00, 8'h00);
        check("pc_is_5", int'(o_instr), 8'h05);
        mid_reset("mid_reset");
        step("seq1", 1'b1, 2'b00, 8'h00);
        step("seq2", 1'b1, 2'b00, 8'h00);
        step("seq3", 1'b1, 2'b00, 8'h00);
        check("prev_lag", int'(o_prev), 8'h02);

        step("rel_minus1", 1'b1, 2'b10, 8'hFF);
        check("rel_minus1_abs", int'(o_instr), 8'h02);
        step("abs_f0", 1'b1, 2'b01, 8'hF0);
        step("rel_wrap", 1'b1, 2'b10, 8'h7F);
        check("rel_wrap_abs", int'(o_instr), 8'h6F);
        step("rel_m128", 1'b1, 2'b10, 8'h80);

        step("abs_78", 1'b1, 2'b01, 8'h78);
        step("hold_seq", 1'b0, 2'b00, 8'h55);
        check("abs_prev_78", int'(o_prev), 8'h78);
        step("hold_abs", 1'b0, 2'b01, 8'hFF);
        step("hold_rel", 1'b0, 2'b10, 8'hAB);
        check("held_78", int'(o_instr), 8'h78);
        step("reenable", 1'b1, 2'b00, 8'h00);
        check("reenable_abs", int'(o_instr), 8'h79);

        step("abs_ff", 1'b1, 2'b01, 8'hFF);
        step("seq_wrap", 1'b1, 2'b00, 8'h00);
        step("mode11", 1'b1, 2'b11, 8'h33);

`ifdef PC_RET_STACK_EN
        mid_reset("stk_reset");
        step("to10", 1'b1, 2'b10, 8'h10);
        step("call40", 1'b1, 2'b01, 8'h40);
        step("ret", 1'b1, 2'b11, 8'h00);
        check("ret_11", int'(o_instr), 8'h11);
        for (int i = 0; i < 5; i++) step("ncall", 1'b1, 2'b01, 8'(8'h20 + i));
        for (int i = 0; i < 5; i++) step("nret", 1'b1, 2'b11, 8'h00);
        check("underflow_pc", int'(o_instr), 8'h00);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mid_reset("rand_reset");
            end
            step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 8-bit program counter for the 8-bit microcontroller datapath. Sits between control unit and instruction memory.
- Each enabled clock it advances sequentially, loads an absolute jump target, or adds a signed relative offset.
- It drives the instruction-memory address and a one-cycle-delayed copy for the execute stage.

Parameters:
- ADDR_W, 8, address width of PC, jump input and both outputs.
- RESET_ADDR, 8'h00, value loaded into PC on reset.
- STACK_DEPTH, 4, return-stack entries; used only with PC_RET_STACK_EN.

Ports:
- i_Clk  in  1  rising-edge clock.
- i_Rst  in  1  asynchronous reset, active-low.
- i_Control_PC  in  1  enable: 1 = update PC per i_Control_Saltos; 0 = hold.
- i_Control_Saltos  in  2  jump mode: 00 sequential, 01 absolute, 10 relative, 11 hold (or return, see Optional Feature).
- i_Direccion_Salto  in  ADDR_W  absolute target (mode 01) or two's-complement offset (mode 10).
- o_Direccion_Instrucciones  out  ADDR_W  current PC register; instruction-memory address.
- o_Direccion_PC  out  ADDR_W  PC value of the previous cycle (address of instruction now executing).

Behaviour:
- One clock domain. Reset is asynchronous, active-low on i_Rst.
- While i_Rst=0: PC = RESET_ADDR, o_Direccion_Instrucciones = RESET_ADDR, o_Direccion_PC = RESET_ADDR. Outputs change immediately, without waiting for a clock.
- On release, the first rising edge performs a normal update.
- Rising edge with i_Control_PC=1:
  - 00: PC <= PC+1.
  - 01: PC <= i_Direccion_Salto.
  - 10: PC <= PC + sign-extended i_Direccion_Salto (8'hFF = -1, 8'h80 = -128).
  - 11: PC unchanged.
- Rising edge with i_Control_PC=0: PC unchanged, regardless of mode and target.
- All arithmetic is modulo 2^ADDR_W; carry/borrow discarded. 8'hFF+1 = 8'h00; 8'h00 + 8'hFF = 8'hFF.
- o_Direccion_PC <= PC on every rising edge, including hold cycles. During a hold it therefore converges to PC after one cycle.
- Latency: new target visible on o_Direccion_Instrucciones one cycle after the edge that samples the inputs. No combinational path from inputs to outputs.
- Inputs are sampled only at the rising edge; changes between edges have no effect.

Optional Feature:
- Macro: PC_RET_STACK_EN.
- Defined:
  - Mode 01 with enable is a call: push PC+1 onto a STACK_DEPTH-entry LIFO, then PC <= i_Direccion_Salto.
  - Mode 11 with enable is a return: pop, PC <= top entry.
  - Push when full overwrites the oldest entry (circular).
  - Pop when empty sets PC <= RESET_ADDR.
  - Added output o_Stack_Err (1 bit): pulses high for one cycle on overflow or underflow.
  - Reset empties the stack and clears o_Stack_Err.
- Undefined: no stack and no o_Stack_Err port; mode 01 is a plain jump and mode 11 is hold.

Decomposition:
- Shared package (pc_pkg):
  - ADDR_W default.
  - Jump-mode constants: PC_SEQ=2'b00, PC_ABS=2'b01, PC_REL=2'b10, PC_HOLD_RET=2'b11.
  - RESET_ADDR default.
- Optional sub-module pc_ret_stack (LIFO with push/pop/full/empty/err), instantiated only under PC_RET_STACK_EN.
- Next-address mux and adder stay in program_counter.

Test Plan:
- Assert i_Rst=0 mid-cycle with PC=8'h05 -> both outputs 8'h00 immediately, before the next edge. Release, enable=1, mode 00 for 3 edges -> PC 01, 02, 03; o_Direccion_PC lags by one: 00, 01, 02.
- PC=8'h03, enable=1, mode 10, offset 8'hFF -> PC 8'h02. Offset 8'h7F from 8'hF0 -> 8'h6F (wrap).
- Enable=1, mode 01, target 8'h78 -> PC 8'h78 next cycle; o_Direccion_PC 8'h78 one cycle later.
- Enable=0 with modes 00/01/10 and targets 8'h55/8'hFF/8'hAB -> PC holds 8'h78 for all three cycles. Re-enable mode 00 -> 8'h79.
- PC=8'hFF, mode 00 -> 8'h00. Mode 11 with enable=1 (macro off) -> PC unchanged.
- Macro on, depth 4:
  - Call 8'h40 from 8'h10 -> PC 8'h40. Return -> PC 8'h11.
  - Five nested calls then five returns -> fifth return errors: o_Stack_Err pulses once, PC 8'h00.
